// File: rtl/exp_controller.sv
// Sequencing FSM for an a^n exponentiation datapath: drives load enables and mux selects.
// Latency: start sampled at edge E0 -> DONE entered at edge E0+2n+3; done lasts one cycle.
// Backpressure: none; start is only accepted in IDLE, abort cancels INIT/CHECK/LOOP.
module exp_controller #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             n_grtr_0,
  output logic             ld_a,
  output logic             ld_n,
  output logic             ld_result,
  output logic             ld_output,
  output logic             sel_n_reg,
  output logic             sel_result_reg,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    LOOP  = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // State register; reset forces IDLE without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and pure state decode of the datapath controls.
  always_comb begin
    state_nxt      = IDLE;
    ld_a           = 1'b0;
    ld_n           = 1'b0;
    ld_result      = 1'b0;
    ld_output      = 1'b0;
    sel_n_reg      = 1'b0;
    sel_result_reg = 1'b0;
    done           = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        // start beats abort here; abort has nothing to cancel in IDLE
        state_nxt = start ? INIT : IDLE;
      end
      INIT: begin
        ld_a      = 1'b1;
        ld_n      = 1'b1;
        ld_result = 1'b1;
        state_nxt = abort ? IDLE : CHECK;
      end
      CHECK: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = n_grtr_0 ? LOOP : OUT;
        end
      end
      LOOP: begin
        ld_result      = 1'b1;
        sel_result_reg = 1'b1;
        ld_n           = 1'b1;
        sel_n_reg      = 1'b1;
        state_nxt      = abort ? IDLE : CHECK;
      end
      OUT: begin
        ld_output = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        // unused codes 6-7 recover to IDLE
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Iteration counter: cleared in INIT, counts LOOP cycles, saturates, holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_cnt <= '0;
    end else if (state == INIT) begin
      iter_cnt <= '0;
    end else if ((state == LOOP) && (iter_cnt != CNT_MAX)) begin
      iter_cnt <= iter_cnt + CNT_ONE;
    end
  end

  assign state_o = state;

endmodule
